// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM states, NOP encoding and default reset PC.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_TRAP
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC datapath: PC+4, aligned branch target, select and misalign detect.
// MISALIGN_TRAP_EN keeps bit 1 of the target and flags taken targets with bit 1 set.
module pc_next_logic (
  input  logic [31:0] pc_i,
  input  logic        next_pc_src_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  // Bit 0 is always dropped (JALR); bit 1 is dropped too when traps are disabled.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target_i[1:0];

  assign pc_plus4_o = pc_i + 32'd4;

`ifdef MISALIGN_TRAP_EN
  assign target_o   = {branch_target_i[31:1], 1'b0};
  assign misalign_o = next_pc_src_i & branch_target_i[1];
`else
  assign target_o   = {branch_target_i[31:2], 2'b00};
  assign misalign_o = 1'b0;
`endif

  assign pc_next_o = next_pc_src_i ? target_o : pc_plus4_o;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM; sole owner of PC state in the core.
// Optional misaligned-target trap is enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        MisalignTrap
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic [31:0]  pc_next;
  logic         misalign;

  pc_next_logic u_pc_next_logic (
    .pc_i            (pc_q),
    .next_pc_src_i   (NextPCSrc),
    .branch_target_i (BranchTarget),
    .pc_plus4_o      (pc_plus4),
    .target_o        (target),
    .pc_next_o       (pc_next),
    .misalign_o      (misalign)
  );

  logic [31:0] unused_target;
  assign unused_target = target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (IMemReady) begin
          inst_d  = IMemRData;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Branch inputs are only consumed on the edge that retires the instruction.
        if (!Stall) begin
          if (misalign) begin
            state_d = S_TRAP;
          end else begin
            pc_d    = pc_next;
            state_d = S_FETCH;
          end
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (state_q == S_EXEC && !Stall && misalign) begin
      trap_q <= 1'b1;
    end
  end

  assign MisalignTrap = trap_q;
`else
  assign MisalignTrap = 1'b0;
`endif

  assign IMemReq   = (state_q == S_FETCH);
  assign InstValid = (state_q == S_EXEC);
  assign IMemAddr  = pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4;
  assign Inst      = inst_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses and instructions are
// queued as stimulus is driven and checked when the DUT presents them.
module tb_pc_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0100;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        NextPCSrc = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        Stall = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemRData = '0;
  logic [31:0] Inst;
  logic        InstValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignTrap;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  logic [31:0] addr_q[$];
  logic [31:0] inst_q[$];

  pc_fetch_unit #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .NextPCSrc    (NextPCSrc),
    .BranchTarget (BranchTarget),
    .Stall        (Stall),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemRData    (IMemRData),
    .Inst         (Inst),
    .InstValid    (InstValid),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .MisalignTrap (MisalignTrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, check reset state, release and enter S_FETCH.
  task automatic do_reset();
    rst = 1'b1;
    IMemReady = 1'b0;
    Stall = 1'b0;
    NextPCSrc = 1'b0;
    repeat (2) step();
    check("rst_req", 32'(IMemReq), 32'd0);
    check("rst_valid", 32'(InstValid), 32'd0);
    check("rst_pc", PC, ResetPc);
    check("rst_inst", Inst, Nop);
    check("rst_trap", 32'(MisalignTrap), 32'd0);
    rst = 1'b0;
    addr_q.delete();
    inst_q.delete();
    step();
    check("idle_req", 32'(IMemReq), 32'd1);
    check("idle_valid", 32'(InstValid), 32'd0);
    addr_q.push_back(ResetPc);
  endtask

  // One full instruction starting in its first S_FETCH cycle.
  task automatic do_inst(input int unsigned waits, input int unsigned stalls,
                         input logic src, input logic [31:0] tgt);
    logic [31:0] pc_m;
    logic [31:0] data;
    int unsigned t0;
    t0 = cyc;
    check("fetch_req", 32'(IMemReq), 32'd1);
    if (addr_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL addr_q: got empty scoreboard, expected a queued address");
      pc_m = PC;
    end else begin
      pc_m = addr_q.pop_front();
    end
    check("fetch_addr", IMemAddr, pc_m);
    check("fetch_valid", 32'(InstValid), 32'd0);
    for (int w = 0; w < int'(waits); w++) begin
      IMemReady = 1'b0;
      IMemRData = $urandom;
      step();
      check("wait_req", 32'(IMemReq), 32'd1);
      check("wait_addr", IMemAddr, pc_m);
      check("wait_valid", 32'(InstValid), 32'd0);
    end
    data = $urandom;
    IMemReady = 1'b1;
    IMemRData = data;
    inst_q.push_back(data);
    step();
    IMemReady = 1'b1;
    IMemRData = $urandom;
    check("exec_valid", 32'(InstValid), 32'd1);
    check("exec_req", 32'(IMemReq), 32'd0);
    check("exec_inst", Inst, inst_q.pop_front());
    check("exec_pc", PC, pc_m);
    check("exec_pc4", PCPlus4, pc_m + 32'd4);
    for (int s = 0; s < int'(stalls); s++) begin
      Stall = 1'b1;
      NextPCSrc = ~src;
      BranchTarget = $urandom;
      step();
      check("stall_valid", 32'(InstValid), 32'd1);
      check("stall_inst", Inst, data);
      check("stall_pc", PC, pc_m);
    end
    Stall = 1'b0;
    IMemReady = 1'b0;
    NextPCSrc = src;
    BranchTarget = tgt;
`ifdef MISALIGN_TRAP_EN
    if (src && tgt[1]) begin
      step();
      NextPCSrc = 1'b0;
      for (int k = 0; k < 3; k++) begin
        IMemReady = 1'b1;
        check("trap_flag", 32'(MisalignTrap), 32'd1);
        check("trap_req", 32'(IMemReq), 32'd0);
        check("trap_valid", 32'(InstValid), 32'd0);
        check("trap_pc", PC, pc_m);
        step();
      end
      IMemReady = 1'b0;
      return;
    end
`endif
    addr_q.push_back(src ? {tgt[31:2], 2'b00} : pc_m + 32'd4);
    step();
    NextPCSrc = 1'b0;
    check("period", cyc - t0, waits + stalls + 2);
  endtask

  initial begin
    #1;
    do_reset();
    do_inst(0, 0, 1'b0, 32'h0);
    do_inst(0, 0, 1'b0, 32'h0);
    do_inst(0, 0, 1'b1, 32'h0000_0200);
    do_inst(3, 2, 1'b1, 32'hFFFF_FFFC);
    do_inst(0, 0, 1'b0, 32'h0);
    do_inst(1, 0, 1'b1, 32'h0000_0203);
`ifndef MISALIGN_TRAP_EN
    do_inst(0, 1, 1'b0, 32'h0);
`endif
    do_reset();
    do_inst(0, 0, 1'b0, 32'h0);
    // Reset during an outstanding fetch, with a late ready in the following cycle.
    check("mid_addr", IMemAddr, addr_q.pop_front());
    IMemReady = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_req", 32'(IMemReq), 32'd0);
    check("mid_rst_valid", 32'(InstValid), 32'd0);
    check("mid_rst_pc", PC, ResetPc);
    check("mid_rst_inst", Inst, Nop);
    rst = 1'b0;
    IMemReady = 1'b1;
    IMemRData = 32'hDEAD_BEEF;
    step();
    IMemReady = 1'b0;
    check("late_valid", 32'(InstValid), 32'd0);
    check("late_req", 32'(IMemReq), 32'd1);
    check("late_inst", Inst, Nop);
    addr_q.push_back(ResetPc);
    do_inst(2, 0, 1'b0, 32'h0);
    check("end_addr", IMemAddr, ResetPc + 32'd4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
